led_frame_sched: RTL

- Frame scheduler for the WS2812 LED chain driver (64 LEDs × 24-bit GRB).
- Holds two 64×24 pixel buffers in ping-pong form. The CPU writes only the back buffer; the driver reads only the front buffer.
- On a CPU swap request, swaps the buffers at a frame boundary, then starts a driver frame with a one-cycle init pulse and waits for the driver's done.
- Enforces a minimum inter-frame gap and a watchdog timeout.

---
 rtl/led_frame_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/led_frame_sched.sv
// Ping-pong frame scheduler for a 64-LED WS2812 chain: CPU fills the back buffer, driver reads the front.
// Optional periodic re-send of the front buffer is enabled with `define LED_AUTO_REFRESH_EN.
module led_frame_sched #(
  parameter int NLEDS          = 64,
  parameter int AW             = 6,
  parameter int DW             = 24,
  parameter int MIN_GAP        = 16,
  parameter int TIMEOUT        = 4000000,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          swap_req,
  input  logic          err_clr,
  input  logic [AW-1:0] drv_address,
  input  logic          drv_done,
  output logic [DW-1:0] drv_data,
  output logic          drv_init,
  output logic          busy,
  output logic          swap_pending,
  output logic          front_sel,
  output logic [15:0]   frame_cnt,
  output logic          timeout_err,
  output logic [1:0]    fsm_state
);

  // Handshake: drv_init is a one-cycle start pulse; drv_done is a level whose rising edge ends the frame.
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2, GAP = 2'd3} state_t;

  localparam logic [AW:0] NLEDS_W = (AW+1)'(NLEDS);

  state_t        state;
  logic [DW-1:0] mem [2][NLEDS];
  logic          done_q;
  logic          done_rise;
  logic [31:0]   wdog;
  logic [31:0]   gap_cnt;
  logic          wr_ok;
  logic          rd_ok;

  assign fsm_state = state;
  assign done_rise = drv_done & ~done_q;
  assign wr_ok     = ({1'b0, cpu_addr} < NLEDS_W);
  assign rd_ok     = ({1'b0, drv_address} < NLEDS_W);
  assign drv_data  = rd_ok ? mem[front_sel][drv_address] : '0;

  // Writes use the pre-edge front_sel, so a write in the commit cycle lands in the buffer becoming front.
  always_ff @(posedge clk) begin
    if (cpu_we && wr_ok) mem[~front_sel][cpu_addr] <= cpu_wdata;
  end

`ifdef LED_AUTO_REFRESH_EN
  logic [31:0] ref_cnt;
  logic        ref_hit;
  logic        refresh;

  assign ref_hit = (ref_cnt == 32'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)          ref_cnt <= '0;
    else if (ref_hit) ref_cnt <= '0;
    else              ref_cnt <= ref_cnt + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      drv_init     <= 1'b0;
      busy         <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      frame_cnt    <= '0;
      timeout_err  <= 1'b0;
      done_q       <= 1'b0;
      wdog         <= '0;
      gap_cnt      <= '0;
`ifdef LED_AUTO_REFRESH_EN
      refresh      <= 1'b0;
`endif
    end else begin
      done_q   <= drv_done;
      drv_init <= 1'b0;
      if (swap_req) swap_pending <= 1'b1;
      if (err_clr)  timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (swap_pending) begin
            front_sel    <= ~front_sel;
            swap_pending <= swap_req;   // a request on the commit edge stays latched
            state        <= START;
            busy         <= 1'b1;
            drv_init     <= 1'b1;
`ifdef LED_AUTO_REFRESH_EN
            refresh      <= 1'b0;
          end else if (refresh) begin
            state        <= START;
            busy         <= 1'b1;
            drv_init     <= 1'b1;
            refresh      <= 1'b0;
`endif
          end
        end
        START: begin
          wdog  <= 32'(TIMEOUT);
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= 32'(MIN_GAP);
            state     <= GAP;
          end else if (wdog <= 32'd1) begin
            // Timeout is assigned after err_clr so it wins on a same-cycle collision.
            timeout_err <= 1'b1;
            wdog        <= '0;
            gap_cnt     <= 32'(MIN_GAP);
            state       <= GAP;
          end else begin
            wdog <= wdog - 32'd1;
          end
        end
        GAP: begin
          if (gap_cnt <= 32'd1) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
`ifdef LED_AUTO_REFRESH_EN
      if (ref_hit) refresh <= 1'b1;
`endif
    end
  end

endmodule
